// File: rtl/fpu_pkg.sv
// ============================================================================
// Package : fpu_pkg
// Purpose : Constants and types shared by the FPU request controller, the
//           combinational FPU datapath and the benches.
//           - FPU operation codes (OP_ADD/OP_SUB/OP_MUL/OP_DIV)
//           - Request-controller state encoding
//           - Settle-counter width
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

    // Operation codes carried on in_op / fpu_op
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Wide enough to hold SETTLE_CYCLES-1 for the full 1..15 range
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } fpu_state_e;

endpackage : fpu_pkg

`default_nettype wire

// File: rtl/fpu_req_ctrl.sv
// ============================================================================
// Module  : fpu_req_ctrl
// Purpose : Request/response sequencer for a downstream combinational FPU.
//           Accepts one operation at a time, holds the operands on the FPU
//           for SETTLE_CYCLES edges, captures result and flags, and presents
//           them on a valid/ready handshake. Keeps sticky exception flags and
//           a saturating count of completed operations.
// Ports   : clk, rst                       - clock, async active-high reset
//           in_valid/in_ready/in_op/in_a/in_b - request side
//           fpu_op/fpu_a/fpu_b             - registered operands to the FPU
//           fpu_result/fpu_error/fpu_underflow/fpu_overflow - FPU outputs
//           out_valid/out_ready/out_result/out_error/out_underflow/out_overflow
//                                          - result side
//           sticky_error/sticky_underflow/sticky_overflow, clr_sticky
//                                          - accumulated flags and their clear
//           busy, op_count                 - status
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_req_ctrl
    import fpu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,

    output logic [1:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic [31:0] fpu_result,
    input  logic        fpu_error,
    input  logic        fpu_underflow,
    input  logic        fpu_overflow,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_error,
    output logic        out_underflow,
    output logic        out_overflow,

    output logic        sticky_error,
    output logic        sticky_underflow,
    output logic        sticky_overflow,
    input  logic        clr_sticky,

    output logic        busy,
    output logic [15:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    fpu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_en_q;
    logic [1:0]        op_q, op_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       res_q, res_d;
    logic              err_q, err_d, unf_q, unf_d, ovf_q, ovf_d;
    logic              s_err_q, s_err_d, s_unf_q, s_unf_d, s_ovf_q, s_ovf_d;
    logic [15:0]       cnt_ops_q, cnt_ops_d;
    logic              capture;

    // rdy_en_q holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rdy_en_q  <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            unf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            s_err_q   <= 1'b0;
            s_unf_q   <= 1'b0;
            s_ovf_q   <= 1'b0;
            cnt_ops_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdy_en_q  <= 1'b1;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            err_q     <= err_d;
            unf_q     <= unf_d;
            ovf_q     <= ovf_d;
            s_err_q   <= s_err_d;
            s_unf_q   <= s_unf_d;
            s_ovf_q   <= s_ovf_d;
            cnt_ops_q <= cnt_ops_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        err_d     = err_q;
        unf_d     = unf_q;
        ovf_d     = ovf_q;
        s_err_d   = s_err_q;
        s_unf_d   = s_unf_q;
        s_ovf_d   = s_ovf_q;
        cnt_ops_d = cnt_ops_q;
        capture   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && rdy_en_q) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // in_valid is deliberately not looked at here
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            res_d     = fpu_result;
            err_d     = fpu_error;
            unf_d     = fpu_underflow;
            ovf_d     = fpu_overflow;
            // A flag raised on the capture edge survives a simultaneous clear
            s_err_d   = (clr_sticky ? 1'b0 : s_err_q) | fpu_error;
            s_unf_d   = (clr_sticky ? 1'b0 : s_unf_q) | fpu_underflow;
            s_ovf_d   = (clr_sticky ? 1'b0 : s_ovf_q) | fpu_overflow;
            cnt_ops_d = (cnt_ops_q == 16'hFFFF) ? cnt_ops_q : cnt_ops_q + 16'd1;
        end else if (clr_sticky) begin
            s_err_d = 1'b0;
            s_unf_d = 1'b0;
            s_ovf_d = 1'b0;
        end
    end

    assign in_ready         = (state_q == ST_IDLE) && rdy_en_q;
    assign out_valid        = (state_q == ST_DONE);
    assign busy             = (state_q == ST_EXEC) || (state_q == ST_DONE);
    assign fpu_op           = op_q;
    assign fpu_a            = a_q;
    assign fpu_b            = b_q;
    assign out_result       = res_q;
    assign out_error        = err_q;
    assign out_underflow    = unf_q;
    assign out_overflow     = ovf_q;
    assign sticky_error     = s_err_q;
    assign sticky_underflow = s_unf_q;
    assign sticky_overflow  = s_ovf_q;
    assign op_count         = cnt_ops_q;

endmodule : fpu_req_ctrl

`default_nettype wire

// File: tb/tb_fpu_req_ctrl.sv
// ============================================================================
// Module  : tb_fpu_req_ctrl
// Purpose : Directed self-checking bench for fpu_req_ctrl (SETTLE_CYCLES=2).
//           A small table-driven FPU stand-in answers the operand pairs used
//           by the vectors below.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_req_ctrl;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_a, fpu_b, fpu_result;
    logic        fpu_error, fpu_underflow, fpu_overflow;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_error, out_underflow, out_overflow;
    logic        sticky_error, sticky_underflow, sticky_overflow, clr_sticky;
    logic        busy;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    always #5 clk = ~clk;

    fpu_req_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_result(fpu_result), .fpu_error(fpu_error),
        .fpu_underflow(fpu_underflow), .fpu_overflow(fpu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_error(out_error), .out_underflow(out_underflow),
        .out_overflow(out_overflow),
        .sticky_error(sticky_error), .sticky_underflow(sticky_underflow),
        .sticky_overflow(sticky_overflow), .clr_sticky(clr_sticky),
        .busy(busy), .op_count(op_count)
    );

    // FPU stand-in: {error, underflow, overflow, result} for known vectors
    always_comb begin
        {fpu_error, fpu_underflow, fpu_overflow, fpu_result} = {3'b000, 32'h0};
        case ({fpu_op, fpu_a, fpu_b})
            {OP_ADD, 32'h40600000, 32'h40200000}: fpu_result = 32'h40C00000;
            {OP_SUB, 32'h40A00000, 32'h3FC00000}: fpu_result = 32'h40600000;
            {OP_MUL, 32'h40000000, 32'h40800000}: fpu_result = 32'h41000000;
            {OP_DIV, 32'h41100000, 32'h40400000}: fpu_result = 32'h40400000;
            {OP_DIV, 32'h40000000, 32'h00000000}:
                {fpu_error, fpu_result} = {1'b1, 32'h7F800000};
            {OP_MUL, 32'h7F7FFFFF, 32'h7F7FFFFF}:
                {fpu_overflow, fpu_result} = {1'b1, 32'h7F800000};
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        in_op = OP_ADD; in_a = '0; in_b = '0;
        tick(); tick();
        #2 rst = 1'b0;
        tick();
    endtask

    // Presents a request, waits (bounded) for in_ready and returns just after
    // the accepting edge with in_valid dropped.
    task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        while (!in_ready && w < 20) begin tick(); w++; end
        if (w >= 20) check("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges until out_valid, bounded at 20
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        in_op = OP_ADD; in_a = '0; in_b = '0;

        // ---- reset state, asserted from time zero
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        check("rst_fpu_a",     fpu_a,          32'd0);
        tick();
        #2 rst = 1'b0;
        #1 check("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
        tick();
        check("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

        // ---- add 3.5 + 2.5
        accept(OP_ADD, 32'h40600000, 32'h40200000);
        check("add_busy",     32'(busy),     32'd1);
        check("add_in_ready", 32'(in_ready), 32'd0);
        check("add_fpu_a",    fpu_a,         32'h40600000);
        wait_valid(lat);
        check("add_latency",  32'(lat),      32'd2);
        check("add_result",   out_result,    32'h40C00000);
        check("add_flags",    32'({out_error, out_underflow, out_overflow}), 32'd0);
        check("add_op_count", 32'(op_count), 32'd1);
        release_result();
        check("add_valid_fall", 32'(out_valid), 32'd0);
        check("add_hold",       out_result,     32'h40C00000);
        check("add_idle_ready", 32'(in_ready),  32'd1);

        // ---- back-to-back: sub then mul with in_valid held high
        apply_reset();
        in_valid = 1'b1; in_op = OP_SUB; in_a = 32'h40A00000; in_b = 32'h3FC00000;
        tick();
        in_op = OP_MUL; in_a = 32'h40000000; in_b = 32'h40800000;
        check("b2b_hold_operand", fpu_a, 32'h40A00000);
        wait_valid(lat);
        check("b2b_sub_latency", 32'(lat),  32'd2);
        check("b2b_sub_result",  out_result, 32'h40600000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("b2b_done_ignores_valid", 32'(busy), 32'd0);
        check("b2b_operand_unchanged",  fpu_a,     32'h40A00000);
        tick();
        in_valid = 1'b0;
        check("b2b_second_accept", fpu_a, 32'h40000000);
        wait_valid(lat);
        check("b2b_mul_result",  out_result,    32'h41000000);
        check("b2b_op_count",    32'(op_count), 32'd2);
        release_result();

        // ---- div with back-pressure
        apply_reset();
        accept(OP_DIV, 32'h41100000, 32'h40400000);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_result",   out_result,     32'h40400000);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            tick();
        end
        release_result();

        // ---- divide by zero, then clear on the next capture edge
        apply_reset();
        accept(OP_DIV, 32'h40000000, 32'h00000000);
        wait_valid(lat);
        check("dz_out_error",    32'(out_error),    32'd1);
        check("dz_sticky_error", 32'(sticky_error), 32'd1);
        release_result();
        accept(OP_ADD, 32'h40600000, 32'h40200000);
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("clr_cap_valid",        32'(out_valid),    32'd1);
        check("clr_cap_sticky_error", 32'(sticky_error), 32'd0);
        check("clr_cap_out_error",    32'(out_error),    32'd0);
        release_result();

        // ---- overflow raised on the same edge as a clear
        apply_reset();
        accept(OP_MUL, 32'h7F7FFFFF, 32'h7F7FFFFF);
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("ovf_out_overflow",    32'(out_overflow),    32'd1);
        check("ovf_sticky_overflow", 32'(sticky_overflow), 32'd1);
        // clear without a capture
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("ovf_clear_no_capture", 32'(sticky_overflow), 32'd0);
        check("ovf_out_kept",         32'(out_overflow),    32'd1);
        release_result();

        // ---- reset mid-EXEC
        apply_reset();
        accept(OP_ADD, 32'h40600000, 32'h40200000);
        tick();
        rst = 1'b1;
        #1;
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_fpu_a",     fpu_a,          32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd0);
        check("arst_op_count",  32'(op_count),  32'd0);
        tick();
        #2 rst = 1'b0;
        #1 check("arst_rel_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("arst_rel_ready_high", 32'(in_ready),   32'd1);
        check("arst_no_capture",     out_result,      32'd0);
        check("arst_count_kept",     32'(op_count),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fpu_req_ctrl

`default_nettype wire
